// File: rtl/verify_collector.sv
// verify_collector: snoops core 7 result reads, checks them against a golden checksum
// and streams the captured 16-word buffer out over a valid/ready port.
module verify_collector #(
    parameter int          BASE         = 32,
    parameter int          SETTLE       = 24,
    parameter int          TIMEOUT      = 4096,
    parameter logic [15:0] EXPECTED_SUM = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] rdata_i,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic        unstable_o,
    output logic [15:0] sum_o,
    output logic [15:0] valid_mask_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [3:0]  out_idx_o,
    output logic [15:0] out_data_o
);
    localparam int CW = $clog2((TIMEOUT > SETTLE ? TIMEOUT : SETTLE) + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_COLLECT, S_DONE, S_DRAIN, S_HOLD} state_t;

    state_t        r_state, w_next;
    logic          r_ready_q;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_buf [16];
    logic [15:0]   r_mask, r_sum;
    logic          r_done, r_pass, r_timeout, r_unstable;
    logic [3:0]    r_idx;

    logic          w_fall, w_rise, w_hit, w_new, w_diff, w_full, w_tmo, w_xfer, w_unused;
    logic [6:0]    w_word, w_off;
    logic [3:0]    w_idx;
    logic [15:0]   w_mask_nxt, w_sum_nxt;

    assign w_fall     = r_ready_q & ~ready_i;
    assign w_rise     = ~r_ready_q & ready_i;
    assign w_word     = adr_i[8:2];
    assign w_off      = w_word - 7'(BASE);
    assign w_idx      = w_off[3:0];
    // an abort on the same cycle suppresses the capture
    assign w_hit      = r_state == S_COLLECT && !w_rise && !we_i && w_word >= 7'(BASE) && w_off < 7'd16;
    assign w_new      = w_hit && !r_mask[w_idx];
    assign w_diff     = w_hit && r_mask[w_idx] && r_buf[w_idx] != rdata_i[15:0];
    assign w_mask_nxt = r_mask | (w_new ? 16'(1) << w_idx : 16'h0000);
    assign w_sum_nxt  = r_sum + (w_new ? rdata_i[15:0] : 16'h0000);
    assign w_full     = &w_mask_nxt;
    assign w_tmo      = r_cnt == CW'(TIMEOUT - 1);
    assign w_xfer     = out_valid_o && out_ready_i;
    assign w_unused   = ^{adr_i[31:9], adr_i[1:0], rdata_i[31:16]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = w_fall ? S_SETTLE : S_IDLE;
            S_SETTLE:  w_next = w_rise ? S_IDLE : (r_cnt == CW'(SETTLE - 1) ? S_COLLECT : S_SETTLE);
            S_COLLECT: w_next = w_rise ? S_IDLE : (w_full || w_tmo ? S_DONE : S_COLLECT);
            S_DONE:    w_next = S_DRAIN;
            S_DRAIN:   w_next = w_rise ? S_IDLE : (w_xfer && &r_idx ? S_HOLD : S_DRAIN);
            S_HOLD:    w_next = w_rise ? S_IDLE : S_HOLD;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ready_q  <= 1'b0;
            r_cnt      <= '0;
            r_mask     <= '0;
            r_sum      <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_unstable <= 1'b0;
            r_idx      <= '0;
            for (int i = 0; i < 16; i++) r_buf[i] <= '0;
        end else begin
            r_state   <= w_next;
            r_ready_q <= ready_i;
            if (r_state == S_IDLE && w_fall) begin
                r_cnt      <= '0;
                r_mask     <= '0;
                r_sum      <= '0;
                r_done     <= 1'b0;
                r_pass     <= 1'b0;
                r_timeout  <= 1'b0;
                r_unstable <= 1'b0;
                r_idx      <= '0;
            end
            if (r_state == S_SETTLE) r_cnt <= w_next == S_COLLECT ? '0 : r_cnt + 1'b1;
            if (r_state == S_COLLECT && !w_rise) begin
                r_cnt  <= r_cnt + 1'b1;
                r_mask <= w_mask_nxt;
                r_sum  <= w_sum_nxt;
                if (w_new) r_buf[w_idx] <= rdata_i[15:0];
                if (w_diff) r_unstable <= 1'b1;
                // completion on the expiry cycle wins over the timeout
                if (w_full || w_tmo) begin
                    r_done    <= 1'b1;
                    r_timeout <= !w_full;
                    r_pass    <= w_full && !r_unstable && w_sum_nxt == EXPECTED_SUM;
                end
            end
            if (w_xfer) r_idx <= r_idx + 1'b1;
        end
    end

    assign done_o       = r_done;
    assign pass_o       = r_pass;
    assign timeout_o    = r_timeout;
    assign unstable_o   = r_unstable;
    assign sum_o        = r_sum;
    assign valid_mask_o = r_mask;
    assign out_valid_o  = r_state == S_DRAIN && !w_rise;
    assign out_idx_o    = r_idx;
    assign out_data_o   = out_valid_o && r_mask[r_idx] ? r_buf[r_idx] : 16'h0000;
endmodule
